seg_scan: RTL and testbench
===========================

# seg_scan

Multiplexed four-digit seven-segment display driver sitting directly downstream of the LC3 core. It latches a 16-bit word selected by the core (register, PC, MAR, MDR or IR contents) and time-multiplexes its four hex nibbles onto the board's single shared segment bus and four digit enables. The core drives `seg_output_single` / `seg_output_sequence` through this block. A frame-boundary update rule prevents a digit scan from mixing two different words.

## Interface
Parameters:
- `COUNTER`, default 2500: clock cycles per digit slot. Legal range is ≥1. At 25 MHz the default gives 100 µs per digit and a 400 µs frame.
- `BLANK_LZ`, default 0: when 1, leading zero digits are blanked. Digit 0 is never blanked.

Ports:
- `clk`  in  1: system clock; all state is updated on the rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `value_in`  in  16: word to display; nibble k appears on digit k.
- `load`  in  1: single-cycle strobe that captures `value_in`. The block is always ready and has no back-pressure.
- `dp_mask`  in  4: decimal-point enable per digit, sampled live at each slot start.
- `seg_output_single`  out  8: segment bus, active-high, bit order {dp,g,f,e,d,c,b,a}.
- `seg_output_sequence`  out  4: one-hot active-high digit enable; bit k selects digit k.
- `frame_done`  out  1: one-cycle pulse on each digit 3→0 wrap.

## Operation
- **State**
  - `div`: 0..COUNTER-1.
  - `digit`: 2 bits.
  - `pending`: 16 bits, the most recently loaded word.
  - `shown`: 16 bits, the word currently being scanned.
  - Output registers for the segment bus, digit enable and `frame_done`.
- **Divider**
  - `div` increments every cycle.
  - When `div` = COUNTER-1 (terminal, "tick"), `div` returns to 0 and `digit` advances 0→1→2→3→0.
  - With COUNTER=1, every cycle is a tick.
- **Load**
  - `load`=1 writes `value_in` into `pending` on that edge.
  - A later `load` in the same frame overwrites `pending`; the last one wins.
- **Frame update**
  - On a tick where `digit` = 3 (wrap), `shown` ← `pending` and `frame_done` pulses.
  - If `load` and the wrap fall in the same cycle, `shown` ← `value_in` directly and `pending` ← `value_in`.
- **Segment encoding** of nibble `shown[4k+3:4k]`, as hex:
  - 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07
  - 8:7F, 9:6F, A:77, b:7C, C:39, d:5E, E:79, F:71
  - Bit 7 (dp) = `dp_mask[k]`.
- **Leading-zero blanking** (`BLANK_LZ`=1)
  - Digit k>0 is blanked if `shown[15:4k]` = 0.
  - A blanked digit outputs segments 8'h00 but still honours its dp bit.
  - The digit enable still asserts, so the scan cadence is unchanged.
- **Register update** on each tick: digit enable, segment bus and `frame_done` are all registered and update together.
  - `seg_output_sequence` ← one-hot of the new digit.
  - `seg_output_single` ← encoding of the new digit, from the `shown` value in effect after this edge.

## Timing
- **Reset values**
  - `div`=0, `digit`=0, `pending`=0, `shown`=0.
  - `seg_output_sequence`=4'b0001.
  - `seg_output_single`=8'h3F (with `dp_mask` ignored during reset).
  - `frame_done`=0.
- **Reset behaviour**
  - Assertion clears all state immediately, independent of `clk`.
  - Reset mid-frame discards `pending` and `shown`.
  - The first tick occurs COUNTER edges after `rst` deasserts.
- **Digit timing**
  - Each digit is held exactly COUNTER cycles.
  - A frame is 4·COUNTER cycles.
  - Outputs change only on tick edges.
- **Load latency**
  - A `load` reaches the display at the next wrap, i.e. on the digit 0 slot, between 1 and 4·COUNTER cycles later.
  - Loads never alter `shown` mid-frame.
- **`frame_done`**
  - High for exactly one cycle: the cycle after the wrap edge, coincident with `seg_output_sequence`=4'b0001.
- **`dp_mask` sampling**
  - Changes take effect at the next tick; there is no frame delay.

## Test plan
- **Reset and scan cadence.** COUNTER=4, `rst` low then high, no load → `seg_output_sequence` cycles 0001→0010→0100→1000 every 4 clocks, segments 3F on every digit, `frame_done` pulses every 16 clocks.
- **Load at frame boundary.** `load` with `value_in`=16'h1A2F mid-frame → the current frame still shows 0000. The next frame shows digit 0=71, 1=5B, 2=77, 3=06.
- **Same-cycle load and wrap.** `load` of 16'hBEEF asserted exactly on the wrap cycle → the following frame shows F/E/E/b (71/79/79/7C). A load of 16'h1234 one cycle earlier in that frame is superseded.
- **Leading-zero blanking.** BLANK_LZ=1, value 16'h0030 → digits 3 and 2 output 00, digit 1=4F, digit 0=3F. Value 16'h0000 → only digit 0 shows 3F.
- **Decimal points.** `dp_mask`=4'b0101, value 16'h8888 → digits 0 and 2 output FF, digits 1 and 3 output 7F.
- **Reset mid-operation and COUNTER=1.** Assert `rst` during the digit 2 slot → outputs return immediately to 0001/3F. With COUNTER=1, the digit advances every clock and `frame_done` pulses every 4 clocks.

Source files
------------

// File: rtl/seg_scan.sv
// seg_scan: four-digit multiplexed seven-segment driver.
// Latches a 16-bit word and scans its nibbles onto a shared segment bus.
// A new word only reaches the display on the digit 3->0 wrap, so a single
// scan never mixes two words.

// Per-digit hex encoder with optional blanking; one instance per digit.
module seg_scan_digit (
  input  logic [3:0] nib,
  input  logic       blank,
  input  logic       dp,
  output logic [7:0] seg
);
  logic [6:0] hex7;

  // Hex nibble to segments {g,f,e,d,c,b,a}
  always_comb begin
    hex7 = 7'h00;
    case (nib)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      4'hF: hex7 = 7'h71;
      default: hex7 = 7'h00;
    endcase
  end

  // Blanked digits drop the segments but keep the decimal point
  assign seg = {dp, blank ? 7'h00 : hex7};
endmodule

module seg_scan #(
  parameter int COUNTER  = 2500,
  parameter bit BLANK_LZ = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value_in,
  input  logic        load,
  input  logic [3:0]  dp_mask,
  output logic [7:0]  seg_output_single,
  output logic [3:0]  seg_output_sequence,
  output logic        frame_done
);
  localparam int DIV_W = (COUNTER > 1) ? $clog2(COUNTER) : 1;
  localparam logic [DIV_W-1:0] DIV_TERM = DIV_W'(COUNTER - 1);

  logic [DIV_W-1:0]      div;
  logic [1:0]            digit;
  logic [1:0]            digit_nxt;
  logic [15:0]           pending;
  logic [15:0]           shown;
  logic [15:0]           shown_nxt;
  logic                  tick;
  logic                  wrap;
  logic [3:0]            blank;
  logic [3:0][7:0]       lane_seg;

  assign tick      = (div == DIV_TERM);
  assign wrap      = tick && (digit == 2'd3);
  assign digit_nxt = digit + 2'd1;
  // A load coinciding with the wrap goes straight to the display
  assign shown_nxt = wrap ? (load ? value_in : pending) : shown;

  // Encoders see the post-edge word so segments and enable move together
  for (genvar k = 0; k < 4; k++) begin : g_dig
    assign blank[k] = BLANK_LZ && (k != 0) && (shown_nxt[15:4*k] == '0);
    seg_scan_digit u_dig (
      .nib   (shown_nxt[4*k+3:4*k]),
      .blank (blank[k]),
      .dp    (dp_mask[k]),
      .seg   (lane_seg[k])
    );
  end

  // Slot divider, digit counter and word latches
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div     <= '0;
      digit   <= 2'd0;
      pending <= 16'h0000;
      shown   <= 16'h0000;
    end else begin
      div <= tick ? '0 : div + 1'b1;
      if (tick) digit <= digit_nxt;
      if (load) pending <= value_in;
      shown <= shown_nxt;
    end
  end

  // Registered outputs, refreshed on each slot tick
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg_output_sequence <= 4'b0001;
      seg_output_single   <= 8'h3F;
      frame_done          <= 1'b0;
    end else begin
      frame_done <= wrap;
      if (tick) begin
        seg_output_sequence <= 4'b0001 << digit_nxt;
        seg_output_single   <= lane_seg[digit_nxt];
      end
    end
  end
endmodule

// File: tb/tb_seg_scan.sv
// tb_seg_scan: directed scoreboard bench for seg_scan.
// Three instances: A (COUNTER=4), B (COUNTER=4, blanking), C (COUNTER=1).
module tb_seg_scan;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b, rst_c;
  logic [15:0] val_a, val_b, val_c;
  logic        load_a, load_b, load_c;
  logic [3:0]  dp_a, dp_b, dp_c;
  logic [7:0]  seg_a, seg_b, seg_c;
  logic [3:0]  seq_a, seq_b, seq_c;
  logic        fd_a, fd_b, fd_c;

  seg_scan #(.COUNTER(4), .BLANK_LZ(1'b0)) u_a (
    .clk(clk), .rst(rst_a), .value_in(val_a), .load(load_a), .dp_mask(dp_a),
    .seg_output_single(seg_a), .seg_output_sequence(seq_a), .frame_done(fd_a));
  seg_scan #(.COUNTER(4), .BLANK_LZ(1'b1)) u_b (
    .clk(clk), .rst(rst_b), .value_in(val_b), .load(load_b), .dp_mask(dp_b),
    .seg_output_single(seg_b), .seg_output_sequence(seq_b), .frame_done(fd_b));
  seg_scan #(.COUNTER(1), .BLANK_LZ(1'b0)) u_c (
    .clk(clk), .rst(rst_c), .value_in(val_c), .load(load_c), .dp_mask(dp_c),
    .seg_output_single(seg_c), .seg_output_sequence(seq_c), .frame_done(fd_c));

  typedef struct packed {
    logic [3:0] seq;
    logic [7:0] seg;
    logic       fd;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  function automatic logic [7:0] enc(logic [15:0] v, int k, logic [3:0] dp, bit blank);
    logic [3:0] n;
    logic [7:0] s;
    n = v[4*k +: 4];
    case (n)
      4'h0: s = 8'h3F; 4'h1: s = 8'h06; 4'h2: s = 8'h5B; 4'h3: s = 8'h4F;
      4'h4: s = 8'h66; 4'h5: s = 8'h6D; 4'h6: s = 8'h7D; 4'h7: s = 8'h07;
      4'h8: s = 8'h7F; 4'h9: s = 8'h6F; 4'hA: s = 8'h77; 4'hB: s = 8'h7C;
      4'hC: s = 8'h39; 4'hD: s = 8'h5E; 4'hE: s = 8'h79; default: s = 8'h71;
    endcase
    if (blank && k > 0 && (v >> (4*k)) == 16'h0000) s = 8'h00;
    s[7] = dp[k];
    return s;
  endfunction

  task automatic push(logic [3:0] seq, logic [7:0] seg, logic fd);
    exp_t e;
    e.seq = seq; e.seg = seg; e.fd = fd;
    sb.push_back(e);
  endtask

  task automatic push_slot(logic [15:0] v, int k, logic [3:0] dp, bit blank, logic fd);
    push(4'(1 << k), enc(v, k, dp, blank), fd);
  endtask

  task automatic push_frame(logic [15:0] v, logic [3:0] dp, bit blank);
    for (int k = 0; k < 4; k++) push_slot(v, k, dp, blank, k == 0);
  endtask

  task automatic chk(string tag, logic [3:0] seq, logic [7:0] seg, logic fd);
    exp_t o, e;
    o.seq = seq; o.seg = seg; o.fd = fd;
    vectors++;
    assert (sb.size() != 0) else begin
      miscompares++;
      $error("FAIL %s: scoreboard empty, got seq=%b seg=%h fd=%b", tag, seq, seg, fd);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      assert (o === e) else begin
        miscompares++;
        $error("FAIL %s: got seq=%b seg=%h fd=%b, expected seq=%b seg=%h fd=%b",
               tag, o.seq, o.seg, o.fd, e.seq, e.seg, e.fd);
      end
    end
  endtask

  task automatic adv(int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    val_a = '0; val_b = '0; val_c = '0;
    load_a = 1'b0; load_b = 1'b0; load_c = 1'b0;
    dp_a = 4'hF; dp_b = 4'b1000; dp_c = 4'h0;
    repeat (3) @(negedge clk);

    // ---- A: reset, cadence, load timing, dp, async reset ----
    push(4'b0001, 8'h3F, 1'b0); chk("a_rst_dp_ignored", seq_a, seg_a, fd_a);
    dp_a = 4'h0; rst_a = 1'b1;
    push_slot(16'h0, 0, 4'h0, 0, 0); chk("a_f0_d0", seq_a, seg_a, fd_a);
    @(negedge clk);
    push_slot(16'h0, 0, 4'h0, 0, 0); chk("a_f0_d0_hold", seq_a, seg_a, fd_a);
    adv(3); push_slot(16'h0, 1, 4'h0, 0, 0); chk("a_f0_d1", seq_a, seg_a, fd_a);
    adv(4); push_slot(16'h0, 2, 4'h0, 0, 0); chk("a_f0_d2", seq_a, seg_a, fd_a);
    adv(4); push_slot(16'h0, 3, 4'h0, 0, 0); chk("a_f0_d3", seq_a, seg_a, fd_a);
    adv(4); push_slot(16'h0, 0, 4'h0, 0, 1); chk("a_f1_wrap", seq_a, seg_a, fd_a);
    @(negedge clk);
    push_slot(16'h0, 0, 4'h0, 0, 0); chk("a_fd_width", seq_a, seg_a, fd_a);
    adv(3); push_slot(16'h0, 1, 4'h0, 0, 0); chk("a_f1_d1", seq_a, seg_a, fd_a);
    val_a = 16'h1A2F; load_a = 1'b1; @(negedge clk); load_a = 1'b0;
    adv(3); push_slot(16'h0, 2, 4'h0, 0, 0); chk("a_no_mid_update_d2", seq_a, seg_a, fd_a);
    adv(4); push_slot(16'h0, 3, 4'h0, 0, 0); chk("a_no_mid_update_d3", seq_a, seg_a, fd_a);
    push_frame(16'h1A2F, 4'h0, 0);
    adv(4); chk("a_1a2f_d0", seq_a, seg_a, fd_a);
    adv(4); chk("a_1a2f_d1", seq_a, seg_a, fd_a);
    adv(4); chk("a_1a2f_d2", seq_a, seg_a, fd_a);
    adv(4); chk("a_1a2f_d3", seq_a, seg_a, fd_a);
    // load one cycle before the wrap, then another on the wrap cycle itself
    adv(2);
    val_a = 16'h1234; load_a = 1'b1; @(negedge clk);
    val_a = 16'hBEEF; @(negedge clk); load_a = 1'b0;
    push_frame(16'hBEEF, 4'h0, 0);
    chk("a_beef_d0", seq_a, seg_a, fd_a);
    adv(4); chk("a_beef_d1", seq_a, seg_a, fd_a);
    adv(4); chk("a_beef_d2", seq_a, seg_a, fd_a);
    adv(4); chk("a_beef_d3", seq_a, seg_a, fd_a);
    dp_a = 4'b0101;
    val_a = 16'h8888; load_a = 1'b1; @(negedge clk); load_a = 1'b0;
    adv(3); push_slot(16'h8888, 0, 4'b0101, 0, 1); chk("a_dp_d0", seq_a, seg_a, fd_a);
    adv(4); push_slot(16'h8888, 1, 4'b0101, 0, 0); chk("a_dp_d1", seq_a, seg_a, fd_a);
    adv(4); push_slot(16'h8888, 2, 4'b0101, 0, 0); chk("a_dp_d2", seq_a, seg_a, fd_a);
    #2 rst_a = 1'b0;
    #1 push(4'b0001, 8'h3F, 1'b0); chk("a_rst_async", seq_a, seg_a, fd_a);
    @(negedge clk); rst_a = 1'b1;
    push(4'b0001, 8'h3F, 1'b0); chk("a_post_rst", seq_a, seg_a, fd_a);
    adv(4); push(4'b0010, 8'h3F, 1'b0); chk("a_post_rst_d1", seq_a, seg_a, fd_a);
    adv(4); push(4'b0100, 8'hBF, 1'b0); chk("a_post_rst_d2", seq_a, seg_a, fd_a);
    adv(4); push(4'b1000, 8'h3F, 1'b0); chk("a_post_rst_d3", seq_a, seg_a, fd_a);
    adv(4); push(4'b0001, 8'hBF, 1'b1); chk("a_pending_cleared", seq_a, seg_a, fd_a);

    // ---- B: leading-zero blanking ----
    rst_b = 1'b1;
    push(4'b0001, 8'h3F, 1'b0); chk("b_f0_d0", seq_b, seg_b, fd_b);
    val_b = 16'h0030; load_b = 1'b1; @(negedge clk); load_b = 1'b0;
    adv(3); push(4'b0010, 8'h00, 1'b0); chk("b_zero_d1", seq_b, seg_b, fd_b);
    adv(4); push(4'b0100, 8'h00, 1'b0); chk("b_zero_d2", seq_b, seg_b, fd_b);
    adv(4); push(4'b1000, 8'h80, 1'b0); chk("b_zero_d3_dp", seq_b, seg_b, fd_b);
    push_frame(16'h0030, 4'b1000, 1);
    adv(4); chk("b_0030_d0", seq_b, seg_b, fd_b);
    adv(4); chk("b_0030_d1", seq_b, seg_b, fd_b);
    adv(4); chk("b_0030_d2", seq_b, seg_b, fd_b);
    adv(4); chk("b_0030_d3", seq_b, seg_b, fd_b);
    val_b = 16'h1000; load_b = 1'b1; @(negedge clk); load_b = 1'b0;
    push_frame(16'h1000, 4'b1000, 1);
    adv(3); chk("b_1000_d0", seq_b, seg_b, fd_b);
    adv(4); chk("b_1000_d1", seq_b, seg_b, fd_b);
    adv(4); chk("b_1000_d2", seq_b, seg_b, fd_b);
    adv(4); chk("b_1000_d3", seq_b, seg_b, fd_b);

    // ---- C: COUNTER=1, digit advances every clock ----
    rst_c = 1'b1;
    push(4'b0001, 8'h3F, 1'b0); chk("c_d0", seq_c, seg_c, fd_c);
    for (int i = 1; i < 8; i++) begin
      adv(1);
      push_slot(16'h0, i % 4, 4'h0, 0, (i % 4) == 0);
      chk("c_scan", seq_c, seg_c, fd_c);
    end
    val_c = 16'h0005; load_c = 1'b1; @(negedge clk); load_c = 1'b0;
    push_frame(16'h0005, 4'h0, 0);
    chk("c_5_d0", seq_c, seg_c, fd_c);
    adv(1); chk("c_5_d1", seq_c, seg_c, fd_c);
    adv(1); chk("c_5_d2", seq_c, seg_c, fd_c);
    adv(1); chk("c_5_d3", seq_c, seg_c, fd_c);
    adv(1); push_slot(16'h0005, 0, 4'h0, 0, 1); chk("c_5_again", seq_c, seg_c, fd_c);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
